// File: rtl/btn_event_gen.sv
// Per-button conditioner: 2-flop synchronizer, debounce FSM and auto-repeat timer.
// Emits registered single-cycle press / event / release pulses plus a debounced level.
module btn_event_gen #(
  parameter int unsigned      N_BTN         = 3,
  parameter int unsigned      DEBOUNCE_CYC  = 250000,
  parameter int unsigned      REPEAT_DELAY  = 12500000,
  parameter int unsigned      REPEAT_PERIOD = 2500000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 3'b011
) (
  input  logic             clk_25mHz,
  input  logic             RSTN,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_evt,
  output logic [N_BTN-1:0] btn_release
);

  localparam int unsigned MAX_AB = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
  localparam int unsigned MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int unsigned CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] RPT_FIRE   = CW'(REPEAT_DELAY);
  // Reload so the next fire lands exactly REPEAT_PERIOD counted cycles later.
  localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DB_DN = 2'd1,
    HELD  = 2'd2,
    DB_UP = 2'd3
  } state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge clk_25mHz or negedge RSTN) begin
    if (!RSTN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] r_rpt;
    logic [CW-1:0] w_rpt_nxt;
    logic          r_level;
    logic          r_press;
    logic          r_evt;
    logic          r_rel;
    logic          w_level_nxt;
    logic          w_press_nxt;
    logic          w_evt_nxt;
    logic          w_rel_nxt;
    logic          w_s;

    assign w_s = r_sync2[g];

    always_ff @(posedge clk_25mHz or negedge RSTN) begin
      if (!RSTN) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_rpt   <= '0;
        r_level <= 1'b0;
        r_press <= 1'b0;
        r_evt   <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_rpt   <= w_rpt_nxt;
        r_level <= w_level_nxt;
        r_press <= w_press_nxt;
        r_evt   <= w_evt_nxt;
        r_rel   <= w_rel_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rpt_nxt   = r_rpt;
      w_press_nxt = 1'b0;
      w_evt_nxt   = 1'b0;
      w_rel_nxt   = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s) begin
            w_state_nxt = DB_DN;
            w_cnt_nxt   = CW'(1);
          end
        end
        DB_DN: begin
          if (!w_s) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DB_LAST) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
            w_rpt_nxt   = '0;
            w_press_nxt = 1'b1;
            w_evt_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        HELD: begin
          // Repeat counter freezes while debouncing a possible release.
          if (!w_s) begin
            w_state_nxt = DB_UP;
            w_cnt_nxt   = CW'(1);
          end else if (REPEAT_MASK[g]) begin
            if (r_rpt == RPT_FIRE) begin
              w_evt_nxt = 1'b1;
              w_rpt_nxt = RPT_RELOAD;
            end else begin
              w_rpt_nxt = r_rpt + CW'(1);
            end
          end
        end
        DB_UP: begin
          if (w_s) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DB_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_rel_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
      w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == DB_UP);
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_evt[g]     = r_evt;
    assign btn_release[g] = r_rel;
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Self-checking bench for btn_event_gen: vector table, directed corner sequences,
// and randomized button activity against a sample-history reference model.
module tb_btn_event_gen;

  localparam int unsigned DB    = 4;
  localparam int unsigned DELAY = 20;
  localparam int unsigned PER   = 8;
  localparam logic [2:0]  MASK  = 3'b011;

  logic       clk = 1'b0;
  logic       RSTN = 1'b0;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] btn_level, btn_press, btn_evt, btn_release;

  int checks = 0;
  int failures = 0;

  btn_event_gen #(
    .N_BTN(3), .DEBOUNCE_CYC(DB), .REPEAT_DELAY(DELAY),
    .REPEAT_PERIOD(PER), .REPEAT_MASK(MASK)
  ) dut (
    .clk_25mHz(clk), .RSTN(RSTN), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_evt(btn_evt), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Reference model: synchronizer pipe, run of samples disagreeing with the
  // accepted level, and count of held cycles for the repeat schedule.
  logic [2:0] m_sync1, m_sync2, m_level, m_prev, e_press, e_evt, e_rel;
  int m_run[3];
  int m_n[3];

  task automatic model_reset();
    m_sync1 = '0; m_sync2 = '0; m_level = '0; m_prev = '0;
    e_press = '0; e_evt = '0; e_rel = '0;
    for (int b = 0; b < 3; b++) begin m_run[b] = 0; m_n[b] = 0; end
  endtask

  task automatic model_edge();
    logic [2:0] s;
    s = m_sync2; m_sync2 = m_sync1; m_sync1 = btn_raw;
    e_press = '0; e_evt = '0; e_rel = '0;
    for (int b = 0; b < 3; b++) begin
      if (m_level[b] && s[b] && m_prev[b]) begin
        m_n[b]++;
        if (MASK[b] && m_n[b] > int'(DELAY) && ((m_n[b] - int'(DELAY) - 1) % int'(PER)) == 0)
          e_evt[b] = 1'b1;
      end
      if (s[b] != m_level[b]) m_run[b]++; else m_run[b] = 0;
      if (m_run[b] == int'(DB)) begin
        m_run[b]   = 0;
        m_level[b] = s[b];
        if (s[b]) begin e_press[b] = 1'b1; e_evt[b] = 1'b1; m_n[b] = 0; end
        else e_rel[b] = 1'b1;
      end
    end
    m_prev = s;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] outs();
    return {btn_level, btn_press, btn_evt, btn_release};
  endfunction

  // One clock: drive at negedge, sample #1 after posedge, compare against model.
  task automatic step(input logic rstn_v, input logic [2:0] raw_v);
    @(negedge clk);
    RSTN = rstn_v; btn_raw = raw_v;
    if (!rstn_v) model_reset();
    @(posedge clk);
    if (rstn_v) model_edge();
    #1;
    chk("model", 32'(outs()), 32'({m_level, e_press, e_evt, e_rel}));
  endtask

  typedef struct {
    logic       rstn;
    logic [2:0] raw;
    logic [11:0] exp;  // {level, press, evt, release}
  } vec_t;
  vec_t tbl[16];

  int evt0, rel0, evt2, rel_idx, prs_idx, p0_idx, p1_idx, idx;

  initial begin
    model_reset();
    // Reset with all held, then press after edge 5; then a bounce from idle.
    tbl[0]  = '{1'b0, 3'b111, 12'h000};
    tbl[1]  = '{1'b1, 3'b111, 12'h000};
    tbl[2]  = '{1'b1, 3'b111, 12'h000};
    tbl[3]  = '{1'b1, 3'b111, 12'h000};
    tbl[4]  = '{1'b1, 3'b111, 12'h000};
    tbl[5]  = '{1'b1, 3'b111, 12'h000};
    tbl[6]  = '{1'b1, 3'b111, {3'b111, 3'b111, 3'b111, 3'b000}};
    tbl[7]  = '{1'b1, 3'b111, {3'b111, 3'b000, 3'b000, 3'b000}};
    tbl[8]  = '{1'b0, 3'b000, 12'h000};
    tbl[9]  = '{1'b1, 3'b001, 12'h000};
    tbl[10] = '{1'b1, 3'b000, 12'h000};
    tbl[11] = '{1'b1, 3'b001, 12'h000};
    tbl[12] = '{1'b1, 3'b000, 12'h000};
    tbl[13] = '{1'b1, 3'b000, 12'h000};
    tbl[14] = '{1'b1, 3'b000, 12'h000};
    tbl[15] = '{1'b1, 3'b000, 12'h000};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rstn, tbl[i].raw);
      chk($sformatf("table[%0d]", i), 32'(outs()), 32'(tbl[i].exp));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 3'b000);

    // Bit0 held 60 cycles: press at step 5, five repeats, release 5 edges after fall.
    evt0 = 0; rel0 = 0; rel_idx = -1; prs_idx = -1;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 3'b001);
      if (btn_evt[0]) evt0++;
      if (btn_press[0] && prs_idx < 0) prs_idx = i;
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 3'b000);
      if (btn_evt[0]) evt0++;
      if (btn_release[0]) begin rel0++; if (rel_idx < 0) rel_idx = i; end
    end
    chk("bit0_press_latency", 32'(prs_idx), 32'd5);
    chk("bit0_evt_count", 32'(evt0), 32'd6);
    chk("bit0_release_count", 32'(rel0), 32'd1);
    chk("bit0_release_latency", 32'(rel_idx), 32'd5);

    // Bit2 held 60 cycles: press only, no repeats.
    evt2 = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 3'b100);
      if (btn_evt[2]) evt2++;
    end
    for (int i = 0; i < 10; i++) step(1'b1, 3'b000);
    chk("bit2_evt_count", 32'(evt2), 32'd1);

    // Bounce while held must not release.
    rel0 = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 3'b001);
    step(1'b1, 3'b000); step(1'b1, 3'b001); step(1'b1, 3'b000); step(1'b1, 3'b001);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'b001);
      if (btn_release[0]) rel0++;
    end
    chk("held_bounce_no_release", 32'(rel0), 32'd0);
    chk("held_bounce_level", 32'(btn_level), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 3'b000);

    // Bits 0 and 1 two cycles apart.
    p0_idx = -1; p1_idx = -1; idx = 0;
    step(1'b1, 3'b001); step(1'b1, 3'b001);
    for (int i = 0; i < 2; i++) begin
      if (btn_press[0] && p0_idx < 0) p0_idx = idx;
      idx++;
    end
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 3'b011);
      if (btn_press[0] && p0_idx < 0) p0_idx = idx;
      if (btn_press[1] && p1_idx < 0) p1_idx = idx;
      idx++;
    end
    chk("two_btn_press0", 32'(p0_idx), 32'd5);
    chk("two_btn_press_gap", 32'(p1_idx - p0_idx), 32'd2);
    for (int i = 0; i < 10; i++) step(1'b1, 3'b000);

    // Reset during debounce and during hold.
    for (int i = 0; i < 4; i++) step(1'b1, 3'b001);
    @(negedge clk); RSTN = 1'b0; model_reset(); #1;
    chk("reset_in_db_dn", 32'(outs()), 32'd0);
    for (int i = 0; i < 9; i++) step(1'b1, 3'b001);
    chk("held_before_reset", 32'(btn_level), 32'd1);
    @(negedge clk); RSTN = 1'b0; model_reset(); #1;
    chk("reset_in_held", 32'(outs()), 32'd0);
    rel0 = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'b000);
      if (btn_release != 3'b000) rel0++;
    end
    chk("no_release_after_reset", 32'(rel0), 32'd0);

    // Randomized activity alternating noisy and calm periods.
    for (int blk = 0; blk < 20; blk++) begin
      int unsigned flip_range;
      logic [2:0] raw;
      flip_range = ($urandom_range(0, 1) == 0) ? 2 : 40;
      raw = btn_raw;
      for (int i = 0; i < 100; i++) begin
        for (int b = 0; b < 3; b++)
          if ($urandom_range(0, flip_range) == 0) raw[b] = ~raw[b];
        if ($urandom_range(0, 799) == 0) step(1'b0, raw);
        else step(1'b1, raw);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
